// File: rtl/slib_mod_counter.sv
// Modulo up/down counter with runtime LIMIT, four boundary modes and registered
// overflow/underflow pulses. Optional enable prescaler: define SLIB_MODCNT_PRESCALER_EN.
module slib_mod_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLEAR,
  input  logic                  LOAD,
  input  logic                  ENABLE,
  input  logic                  DOWN,
  input  logic [1:0]            MODE,
  input  logic [WIDTH-1:0]      D,
  input  logic [WIDTH-1:0]      LIMIT,
`ifdef SLIB_MODCNT_PRESCALER_EN
  input  logic [PRESCALE_W-1:0] PRESCALE,
`endif
  output logic [WIDTH-1:0]      Q,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic                  TC,
  output logic                  ACTIVE
);

  localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);
  localparam logic [1:0]       M_WRAP = 2'b00;
  localparam logic [1:0]       M_ONE  = 2'b10;
  localparam logic [1:0]       M_RELD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_started;
  logic             w_oneshot;
  logic             w_run_ok;
  logic             w_tick;
  logic             w_step;
  logic             w_tc;

  // Value Q takes on a step; boundary handling depends on direction and mode.
  function automatic logic [WIDTH-1:0] f_next(
    input logic [WIDTH-1:0] q,
    input logic             down,
    input logic [1:0]       mode,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] lim
  );
    logic [WIDTH-1:0] v;
    v = q;
    if (!down) begin
      if (q < lim)             v = q + L_ONE;
      else if (mode == M_WRAP) v = '0;
      else if (mode == M_RELD) v = d;
    end else begin
      if (q != '0)             v = q - L_ONE;
      else if (mode == M_WRAP) v = lim;
      else if (mode == M_RELD) v = d;
    end
    return v;
  endfunction

  assign w_oneshot = (MODE == M_ONE);
  assign w_run_ok  = !w_oneshot || (r_state == S_RUN);
  assign w_tc      = DOWN ? (Q == '0) : (Q >= LIMIT);
  assign TC        = w_tc;
  assign ACTIVE    = r_started & w_run_ok;
  assign w_step    = ENABLE & !CLEAR & !LOAD & w_tick & w_run_ok;

`ifdef SLIB_MODCNT_PRESCALER_EN
  localparam logic [PRESCALE_W-1:0] L_PONE = PRESCALE_W'(1);
  logic [PRESCALE_W-1:0] r_pre;

  assign w_tick = (r_pre == PRESCALE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                r_pre <= '0;
    else if (CLEAR || LOAD) r_pre <= '0;
    else if (ENABLE)        r_pre <= w_tick ? '0 : r_pre + L_PONE;
  end
`else
  // Without the prescaler every enabled cycle is a tick (PRESCALE_W is always >= 1).
  assign w_tick = (PRESCALE_W > 0);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q         <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (CLEAR) begin
        Q         <= '0;
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else if (LOAD) begin
        Q         <= D;
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else begin
        OVERFLOW  <= w_step & !DOWN & w_tc;
        UNDERFLOW <= w_step &  DOWN & w_tc;
        if (w_step) Q <= f_next(Q, DOWN, MODE, D, LIMIT);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // One-shot sequencing; any other mode parks the FSM in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_oneshot || CLEAR)  w_state_nxt = S_IDLE;
    else if (LOAD)            w_state_nxt = S_RUN;
    else if (w_step && w_tc)  w_state_nxt = S_DONE;
  end

endmodule

// File: tb/tb_slib_mod_counter.sv
// Bench for slib_mod_counter: directed test-plan sequences with literal expectations
// plus randomized stimulus compared every cycle against a behavioural model.
module tb_slib_mod_counter;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CLEAR = 1'b0, LOAD = 1'b0, ENABLE = 1'b0, DOWN = 1'b0;
  logic [1:0]   MODE = 2'b00;
  logic [W-1:0] D = '0, LIMIT = '0;
`ifdef SLIB_MODCNT_PRESCALER_EN
  logic [3:0]   PRESCALE = 4'd0;
`endif
  logic [W-1:0] Q;
  logic         OVERFLOW, UNDERFLOW, TC, ACTIVE;

  int total = 0;
  int bad   = 0;

  // Model state: count, prescaler, one-shot phase (0 idle, 1 run, 2 done), pulses.
  int mq = 0, mpre = 0, mst = 0;
  bit movf = 0, munf = 0, mstarted = 0;

  slib_mod_counter #(.WIDTH(W), .PRESCALE_W(4)) dut (
    .CLK(CLK), .RST(RST), .CLEAR(CLEAR), .LOAD(LOAD), .ENABLE(ENABLE),
    .DOWN(DOWN), .MODE(MODE), .D(D), .LIMIT(LIMIT),
`ifdef SLIB_MODCNT_PRESCALER_EN
    .PRESCALE(PRESCALE),
`endif
    .Q(Q), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .TC(TC), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: what one clock edge does according to the rules.
  always @(posedge CLK or posedge RST) begin
    int nq, ns, tick;
    bit o, u, go;
    if (RST) begin
      mq <= 0; mpre <= 0; mst <= 0; movf <= 0; munf <= 0; mstarted <= 0;
    end else begin
      mstarted <= 1;
      if (CLEAR) begin
        mq <= 0; mpre <= 0; mst <= 0; movf <= 0; munf <= 0;
      end else if (LOAD) begin
        mq <= int'(D); mpre <= 0; mst <= (MODE == 2) ? 1 : 0; movf <= 0; munf <= 0;
      end else begin
        tick = 1;
`ifdef SLIB_MODCNT_PRESCALER_EN
        tick = (mpre == int'(PRESCALE)) ? 1 : 0;
        if (ENABLE) mpre <= (tick == 1) ? 0 : mpre + 1;
`endif
        go = ENABLE && (tick == 1) && (MODE != 2 || mst == 1);
        nq = mq; ns = mst; o = 0; u = 0;
        if (go) begin
          if (!DOWN) begin
            if (mq < int'(LIMIT)) nq = mq + 1;
            else begin
              o  = 1;
              nq = (MODE == 0) ? 0 : (MODE == 3) ? int'(D) : mq;
              if (MODE == 2) ns = 2;
            end
          end else begin
            if (mq > 0) nq = mq - 1;
            else begin
              u  = 1;
              nq = (MODE == 0) ? int'(LIMIT) : (MODE == 3) ? int'(D) : mq;
              if (MODE == 2) ns = 2;
            end
          end
        end
        if (MODE != 2) ns = 0;
        mq <= nq; mst <= ns; movf <= o; munf <= u;
      end
    end
  end

  // Single compare point, half a period away from the active edge.
  always @(negedge CLK) begin
    chk("Q", Q, mq);
    chk("OVERFLOW", OVERFLOW, movf);
    chk("UNDERFLOW", UNDERFLOW, munf);
    chk("TC", TC, DOWN ? (mq == 0) : (mq >= int'(LIMIT)));
    chk("ACTIVE", ACTIVE, mstarted && (MODE != 2 || mst == 1));
  end

  // Drive one cycle of inputs (called just after a rising edge), then step past the next edge.
  task automatic cyc(input bit clr, input bit ld, input bit en, input bit dn,
                     input logic [1:0] md, input logic [W-1:0] d, input logic [W-1:0] lim);
    CLEAR = clr; LOAD = ld; ENABLE = en; DOWN = dn; MODE = md; D = d; LIMIT = lim;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int e1[7] = '{1, 2, 3, 4, 5, 0, 1};
    int e2[3] = '{0, 5, 4};
    int e3[6] = '{1, 2, 3, 3, 3, 3};
    int e4[4] = '{1, 0, 0, 0};
    int e5[4] = '{8, 9, 7, 8};

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_Q", Q, 0);
    chk("rst_OVF", OVERFLOW, 0);
    chk("rst_UNF", UNDERFLOW, 0);
    chk("rst_ACTIVE", ACTIVE, 0);
    chk("rst_TC", TC, 1);
    RST = 1'b0;
    cyc(0, 0, 0, 0, 2'b00, 0, 0);
    chk("active_after_first_clk", ACTIVE, 1);

    cyc(1, 0, 0, 0, 2'b00, 0, 5);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 1, 0, 2'b00, 0, 5);
      chk("wrap_up_Q", Q, e1[i]);
      chk("wrap_up_OVF", OVERFLOW, e1[i] == 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 2'b00, 0, 5);
      chk("wrap_dn_Q", Q, e2[i]);
      chk("wrap_dn_UNF", UNDERFLOW, e2[i] == 5);
    end

    cyc(1, 0, 0, 0, 2'b01, 0, 3);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0, 2'b01, 0, 3);
      chk("sat_Q", Q, e3[i]);
      chk("sat_OVF", OVERFLOW, i >= 3);
      chk("sat_TC", TC, e3[i] == 3);
    end

    cyc(1, 0, 0, 1, 2'b10, 2, 9);
    chk("os_idle_ACTIVE", ACTIVE, 0);
    cyc(0, 1, 0, 1, 2'b10, 2, 9);
    chk("os_load_Q", Q, 2);
    chk("os_load_ACTIVE", ACTIVE, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 1, 2'b10, 2, 9);
      chk("os_Q", Q, e4[i]);
      chk("os_UNF", UNDERFLOW, i == 2);
      chk("os_ACTIVE", ACTIVE, i < 2);
    end
    cyc(0, 1, 0, 1, 2'b10, 2, 9);
    chk("os_rearm_ACTIVE", ACTIVE, 1);
    chk("os_rearm_Q", Q, 2);

    cyc(0, 1, 0, 0, 2'b11, 7, 9);
    chk("rl_load_Q", Q, 7);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 2'b11, 7, 9);
      chk("rl_Q", Q, e5[i]);
      chk("rl_OVF", OVERFLOW, i == 2);
    end
    cyc(1, 1, 1, 0, 2'b11, 7, 9);
    chk("clr_ld_en_Q", Q, 0);
    cyc(0, 0, 1, 0, 2'b11, 7, 9);
    cyc(0, 0, 1, 0, 2'b11, 7, 9);
    chk("pre_rst_Q", Q, 2);
    #2 RST = 1'b1;
    #1;
    chk("async_rst_Q", Q, 0);
    chk("async_rst_ACTIVE", ACTIVE, 0);
    @(posedge CLK);
    #1 RST = 1'b0;
    cyc(0, 0, 0, 0, 2'b11, 7, 9);
    chk("post_rst_ACTIVE", ACTIVE, 1);

`ifdef SLIB_MODCNT_PRESCALER_EN
    PRESCALE = 4'd2;
    cyc(1, 0, 0, 0, 2'b00, 0, 15);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 1, 0, 2'b00, 0, 15);
      chk("pre_Q", Q, i / 3);
    end
    cyc(0, 0, 1, 0, 2'b00, 0, 15);
    cyc(0, 0, 1, 0, 2'b00, 0, 15);
    cyc(0, 0, 0, 0, 2'b00, 0, 15);
    cyc(0, 0, 0, 0, 2'b00, 0, 15);
    chk("pre_hold_Q", Q, 3);
    cyc(0, 0, 1, 0, 2'b00, 0, 15);
    chk("pre_resume_Q", Q, 4);
`endif

    begin
      logic [1:0]   md  = 2'b00;
      logic [W-1:0] lim = 8'd6;
      for (int n = 0; n < 2000; n++) begin
        if ($urandom_range(0, 29) == 0) md  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) lim = W'($urandom_range(0, 12));
`ifdef SLIB_MODCNT_PRESCALER_EN
        if ($urandom_range(0, 49) == 0) PRESCALE = 4'($urandom_range(0, 3));
`endif
        cyc($urandom_range(0, 39) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            md, W'($urandom_range(0, 15)), lim);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
